instr_fetch: RTL and testbench

- Fetch front-end that reads the byte-wide program store (registered read, 1-cycle latency) and presents complete instructions to the control unit.
- Drives the store read address and assembles opcode plus optional 8-bit operand; LDACI, STACI and JPNZ carry an operand.
- Hands each instruction over with a valid/ready handshake, then waits for a completion pulse that may carry a jump.
- Sits between the instruction memory read port and the control FSM.

---
 rtl/instr_fetch.sv | 157 +++++++++++++++
 tb/tb_instr_fetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch front-end: reads opcode and optional operand bytes from a
// registered-read program store and hands them to the control unit.
module instr_fetch #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] mem_r_addr,
   input  logic [DATA_WIDTH-1:0] mem_r_instr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] opcode,
   output logic [DATA_WIDTH-1:0] operand,
   output logic                  has_operand,
   output logic                  illegal,
   input  logic                  instr_done,
   input  logic                  jump_en,
   input  logic [ADDR_WIDTH-1:0] jump_addr,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  halted,
   output logic                  busy
);

   localparam logic [DATA_WIDTH-1:0] OP_LDACI   = DATA_WIDTH'(0);
   localparam logic [DATA_WIDTH-1:0] OP_STACI   = DATA_WIDTH'(13);
   localparam logic [DATA_WIDTH-1:0] OP_JPNZ    = DATA_WIDTH'(27);
   localparam logic [DATA_WIDTH-1:0] OP_ENDOP   = DATA_WIDTH'(28);
   localparam logic [DATA_WIDTH-1:0] OP_MAX_LEG = DATA_WIDTH'(34);

   typedef enum logic [2:0] {
      S_IDLE, S_F_OP, S_W_OP, S_F_IMM, S_W_IMM, S_ISSUE, S_EXEC, S_HALT
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
   logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
   logic [DATA_WIDTH-1:0]   operand_q, operand_d;
   logic                    has_operand_q, has_operand_d;
   logic                    illegal_q, illegal_d;
   logic                    instr_valid_q, instr_valid_d;
   logic                    halted_q, halted_d;
   logic                    busy_q, busy_d;
   logic                    dec_has_operand;

   // The fetch address register doubles as the program counter: it always
   // points at the next byte to read, so pc and mem_r_addr are the same value.
   assign mem_r_addr  = fetch_addr_q;
   assign pc          = fetch_addr_q;
   assign instr_valid = instr_valid_q;
   assign opcode      = opcode_q;
   assign operand     = operand_q;
   assign has_operand = has_operand_q;
   assign illegal     = illegal_q;
   assign halted      = halted_q;
   assign busy        = busy_q;

   assign dec_has_operand = (mem_r_instr == OP_LDACI) || (mem_r_instr == OP_STACI) ||
                            (mem_r_instr == OP_JPNZ);

   always_comb begin
      state_d       = state_q;
      fetch_addr_d  = fetch_addr_q;
      opcode_d      = opcode_q;
      operand_d     = operand_q;
      has_operand_d = has_operand_q;
      illegal_d     = illegal_q;
      instr_valid_d = instr_valid_q;
      halted_d      = halted_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_F_OP;
               fetch_addr_d = START_ADDR;
            end
         end
         S_F_OP: begin
            state_d      = S_W_OP;
            fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
         end
         S_W_OP: begin
            opcode_d      = mem_r_instr;
            has_operand_d = dec_has_operand;
            illegal_d     = mem_r_instr > OP_MAX_LEG;
            if (dec_has_operand) begin
               state_d = S_F_IMM;
            end else begin
               state_d       = S_ISSUE;
               operand_d     = '0;
               instr_valid_d = 1'b1;
            end
         end
         S_F_IMM: begin
            state_d      = S_W_IMM;
            fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
         end
         S_W_IMM: begin
            state_d       = S_ISSUE;
            operand_d     = mem_r_instr;
            instr_valid_d = 1'b1;
         end
         S_ISSUE: begin
            if (instr_ready) begin
               state_d       = S_EXEC;
               instr_valid_d = 1'b0;
            end
         end
         S_EXEC: begin
            if (instr_done) begin
               if (jump_en) fetch_addr_d = jump_addr;
               if (opcode_q == OP_ENDOP) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d = S_F_OP;
               end
            end
         end
         S_HALT: begin
            if (start) begin
               state_d      = S_F_OP;
               halted_d     = 1'b0;
               fetch_addr_d = START_ADDR;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         fetch_addr_q  <= START_ADDR;
         opcode_q      <= '0;
         operand_q     <= '0;
         has_operand_q <= 1'b0;
         illegal_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         opcode_q      <= opcode_d;
         operand_q     <= operand_d;
         has_operand_q <= has_operand_d;
         illegal_q     <= illegal_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
         busy_q        <= busy_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a small program walks through 2-byte, stalled,
// illegal, jump, halt, wrap-around and asynchronous-reset scenarios.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst_n, start, instr_ready, instr_done, jump_en;
   logic [7:0] mem_r_instr, jump_addr;
   logic [7:0] mem_r_addr, opcode, operand, pc;
   logic       instr_valid, has_operand, illegal, halted, busy;
   logic [7:0] mem [256];
   int         checks = 0;
   int         errors = 0;

   instr_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .START_ADDR(8'd0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mem_r_addr(mem_r_addr), .mem_r_instr(mem_r_instr),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .operand(operand), .has_operand(has_operand), .illegal(illegal),
      .instr_done(instr_done), .jump_en(jump_en), .jump_addr(jump_addr),
      .pc(pc), .halted(halted), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_r_instr <= mem[mem_r_addr];

   always @(posedge clk)
      if (instr_valid && instr_ready)
         $display("txn: opcode=%0d operand=%0d has_operand=%0d illegal=%0d pc=%0d",
                  opcode, operand, has_operand, illegal, pc);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic handshake();
      instr_ready = 1'b1; tick(); instr_ready = 1'b0;
   endtask

   task automatic done_pulse(input logic jmp, input logic [7:0] target);
      instr_done = 1'b1; jump_en = jmp; jump_addr = target;
      tick();
      instr_done = 1'b0; jump_en = 1'b0; jump_addr = 8'd0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d exp 0", instr_valid); end
      checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_busy_halted got %0d/%0d exp 0/0", busy, halted); end
      checks++; if (pc !== 8'd0 || mem_r_addr !== 8'd0) begin errors++; $display("FAIL rst_pc got %0d/%0d exp 0/0", pc, mem_r_addr); end
      checks++; if (opcode !== 8'd0 || operand !== 8'd0 || has_operand !== 1'b0 || illegal !== 1'b0) begin
         errors++; $display("FAIL rst_instr got op=%0d opd=%0d has=%0d ill=%0d exp all 0", opcode, operand, has_operand, illegal); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (busy !== 1'b0 || mem_r_addr !== 8'd0) begin errors++; $display("FAIL idle_no_fetch got busy=%0d addr=%0d exp 0/0", busy, mem_r_addr); end
   endtask

   task automatic test_two_byte();
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (mem_r_addr !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL fop_addr got addr=%0d busy=%0d exp 0/1", mem_r_addr, busy); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wop_valid got %0d exp 0", instr_valid); end
      tick();
      checks++; if (mem_r_addr !== 8'd1) begin errors++; $display("FAIL fimm_addr got %0d exp 1", mem_r_addr); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wimm_valid got %0d exp 0", instr_valid); end
      tick();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL lat4_valid got %0d exp 1", instr_valid); end
      checks++; if (opcode !== 8'd0 || operand !== 8'd5 || has_operand !== 1'b1 || pc !== 8'd2) begin
         errors++; $display("FAIL ldaci_fields got op=%0d opd=%0d has=%0d pc=%0d exp 0/5/1/2", opcode, operand, has_operand, pc); end
      handshake();
      checks++; if (instr_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL exec_valid got valid=%0d busy=%0d exp 0/1", instr_valid, busy); end
      done_pulse(1'b0, 8'd0);
      checks++; if (mem_r_addr !== 8'd2) begin errors++; $display("FAIL next_fetch got %0d exp 2", mem_r_addr); end
   endtask

   task automatic test_ready_stall();
      tick(); tick();
      checks++; if (instr_valid !== 1'b1 || opcode !== 8'd4 || has_operand !== 1'b0 || operand !== 8'd0) begin
         errors++; $display("FAIL mvac_lat2 got valid=%0d op=%0d has=%0d opd=%0d exp 1/4/0/0", instr_valid, opcode, has_operand, operand); end
      instr_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (instr_valid !== 1'b1 || opcode !== 8'd4) begin errors++; $display("FAIL stall_hold got valid=%0d op=%0d exp 1/4", instr_valid, opcode); end
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0; instr_done = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_exec got valid=%0d exp 0", instr_valid); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (instr_valid !== 1'b0 || busy !== 1'b1 || mem_r_addr !== 8'd3) begin
            errors++; $display("FAIL exec_wait got valid=%0d busy=%0d addr=%0d exp 0/1/3", instr_valid, busy, mem_r_addr); end
      end
      done_pulse(1'b0, 8'd0);
      checks++; if (mem_r_addr !== 8'd3) begin errors++; $display("FAIL after_stall_addr got %0d exp 3", mem_r_addr); end
   endtask

   task automatic test_illegal();
      tick(); tick();
      checks++; if (instr_valid !== 1'b1 || illegal !== 1'b1 || has_operand !== 1'b0 || opcode !== 8'd40 || operand !== 8'd0) begin
         errors++; $display("FAIL illegal_fields got valid=%0d ill=%0d has=%0d op=%0d opd=%0d exp 1/1/0/40/0", instr_valid, illegal, has_operand, opcode, operand); end
      handshake();
      done_pulse(1'b1, 8'd55);
      checks++; if (mem_r_addr !== 8'd55) begin errors++; $display("FAIL jump55 got %0d exp 55", mem_r_addr); end
   endtask

   task automatic test_jump();
      for (int i = 0; i < 4; i++) tick();
      checks++; if (opcode !== 8'd27 || operand !== 8'd27 || has_operand !== 1'b1 || illegal !== 1'b0 || pc !== 8'd57) begin
         errors++; $display("FAIL jpnz_fields got op=%0d opd=%0d has=%0d ill=%0d pc=%0d exp 27/27/1/0/57", opcode, operand, has_operand, illegal, pc); end
      handshake();
      jump_en = 1'b1; jump_addr = 8'd99; tick(); jump_en = 1'b0;
      checks++; if (mem_r_addr !== 8'd57 || busy !== 1'b1) begin errors++; $display("FAIL jump_no_done got addr=%0d busy=%0d exp 57/1", mem_r_addr, busy); end
      done_pulse(1'b1, 8'd27);
      checks++; if (mem_r_addr !== 8'd27) begin errors++; $display("FAIL jump_taken got %0d exp 27", mem_r_addr); end
      tick(); tick(); handshake();
      done_pulse(1'b1, 8'd55);
      for (int i = 0; i < 4; i++) tick();
      handshake();
      done_pulse(1'b0, 8'd200);
      checks++; if (mem_r_addr !== 8'd57) begin errors++; $display("FAIL jump_not_taken got %0d exp 57", mem_r_addr); end
   endtask

   task automatic test_halt();
      tick(); tick(); handshake();
      done_pulse(1'b1, 8'd92);
      tick(); tick();
      checks++; if (opcode !== 8'd28 || instr_valid !== 1'b1) begin errors++; $display("FAIL endop_issue got op=%0d valid=%0d exp 28/1", opcode, instr_valid); end
      handshake();
      done_pulse(1'b0, 8'd0);
      checks++; if (halted !== 1'b1 || busy !== 1'b0 || mem_r_addr !== 8'd93 || pc !== 8'd93) begin
         errors++; $display("FAIL halt_state got halted=%0d busy=%0d addr=%0d pc=%0d exp 1/0/93/93", halted, busy, mem_r_addr, pc); end
      done_pulse(1'b1, 8'd10);
      tick();
      checks++; if (halted !== 1'b1 || mem_r_addr !== 8'd93) begin errors++; $display("FAIL halt_frozen got halted=%0d addr=%0d exp 1/93", halted, mem_r_addr); end
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (halted !== 1'b0 || busy !== 1'b1 || mem_r_addr !== 8'd0) begin
         errors++; $display("FAIL restart got halted=%0d busy=%0d addr=%0d exp 0/1/0", halted, busy, mem_r_addr); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) tick();
      handshake();
      mem[0] = 8'hA5;
      done_pulse(1'b1, 8'd255);
      tick();
      checks++; if (mem_r_addr !== 8'd0) begin errors++; $display("FAIL wrap_pc got %0d exp 0", mem_r_addr); end
      tick(); tick(); tick();
      checks++; if (opcode !== 8'd13 || operand !== 8'hA5 || has_operand !== 1'b1 || pc !== 8'd1) begin
         errors++; $display("FAIL wrap_staci got op=%0d opd=%0d has=%0d pc=%0d exp 13/165/1/1", opcode, operand, has_operand, pc); end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0; #2;
      checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || pc !== 8'd0 || opcode !== 8'd0 || operand !== 8'd0 || has_operand !== 1'b0) begin
         errors++; $display("FAIL rst_issue got valid=%0d busy=%0d pc=%0d op=%0d opd=%0d has=%0d exp all 0", instr_valid, busy, pc, opcode, operand, has_operand); end
      rst_n = 1'b1;
      mem[0] = 8'd0;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (busy !== 1'b0 || mem_r_addr !== 8'd0 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL rst_idle got busy=%0d addr=%0d valid=%0d exp 0/0/0", busy, mem_r_addr, instr_valid); end
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      checks++; if (pc !== 8'd2 || has_operand !== 1'b1) begin errors++; $display("FAIL in_wimm got pc=%0d has=%0d exp 2/1", pc, has_operand); end
      rst_n = 1'b0; #2;
      checks++; if (pc !== 8'd0 || busy !== 1'b0 || has_operand !== 1'b0 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL rst_wimm got pc=%0d busy=%0d has=%0d valid=%0d exp 0/0/0/0", pc, busy, has_operand, instr_valid); end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (busy !== 1'b0 || mem_r_addr !== 8'd0 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL rst_wimm_idle got busy=%0d addr=%0d valid=%0d exp 0/0/0", busy, mem_r_addr, instr_valid); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0; instr_done = 1'b0;
      jump_en = 1'b0; jump_addr = 8'd0;
      for (int i = 0; i < 256; i++) mem[i] = 8'd0;
      mem[0] = 8'd0;   mem[1] = 8'd5;   mem[2] = 8'd4;   mem[3] = 8'd40;
      mem[27] = 8'd4;  mem[55] = 8'd27; mem[56] = 8'd27; mem[57] = 8'd4;
      mem[92] = 8'd28; mem[255] = 8'd13;
      test_reset();
      test_two_byte();
      test_ready_stall();
      test_illegal();
      test_jump();
      test_halt();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
